apb_rr_master: RTL and testbench

//  APB master with round-robin arbitration. Shares one APB slave port (e.g. the RAM-backed APB slave)

---
 rtl/apb_pkg.sv | 13 +
 rtl/apb_rr_arbiter.sv | 33 +++
 rtl/apb_rr_master.sv | 116 +++++++++++
 tb/tb_apb_rr_master.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared types and default widths for the round-robin APB master.
package apb_pkg;

  typedef enum logic [1:0] {
    APB_IDLE   = 2'b00,
    APB_SETUP  = 2'b01,
    APB_ACCESS = 2'b10
  } apb_state_t;

  localparam int APB_ADDR_WIDTH = 32;
  localparam int APB_DATA_WIDTH = 32;

endpackage

// File: rtl/apb_rr_arbiter.sv
// Rotating-priority arbiter: the first asserted request after ptr (with
// wrap-around) wins. Purely combinational; the pointer lives in the parent.
module apb_rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         gnt,
  output logic [$clog2(NREQ)-1:0] idx,
  output logic                    found
);

  localparam int IW = $clog2(NREQ);

  logic [IW-1:0] cand;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    // Scan ptr+1 .. ptr+NREQ so the last winner has the lowest priority.
    for (int i = 1; i <= NREQ; i++) begin
      cand = IW'((int'(ptr) + i) % NREQ);
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/apb_rr_master.sv
// APB master sharing one slave port between NREQ requesters with round-robin
// arbitration, pready wait states and a wait-state timeout abort.
module apb_rr_master
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH = APB_ADDR_WIDTH,
  parameter int DATA_WIDTH = APB_DATA_WIDTH,
  parameter int NREQ       = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                       pclk,
  input  logic                       presetn,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ-1:0]            req_write,
  input  logic [NREQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NREQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NREQ-1:0]            req_ready,
  output logic [NREQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]      rsp_rdata,
  output logic                       rsp_err,
  output logic                       psel,
  output logic                       penable,
  output logic                       pwrite,
  output logic [ADDR_WIDTH-1:0]      paddr,
  output logic [DATA_WIDTH-1:0]      pwdata,
  input  logic [DATA_WIDTH-1:0]      prdata,
  input  logic                       pready
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

  apb_state_t      state;
  logic [IW-1:0]   ptr;
  logic [NREQ-1:0] gnt_q;
  logic [CW-1:0]   wcnt;

  logic [NREQ-1:0] arb_gnt;
  logic [IW-1:0]   arb_idx;
  logic            arb_found;

  apb_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req   (req_valid),
    .ptr   (ptr),
    .gnt   (arb_gnt),
    .idx   (arb_idx),
    .found (arb_found)
  );

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state     <= APB_IDLE;
      ptr       <= IW'(NREQ - 1);
      gnt_q     <= '0;
      wcnt      <= '0;
      req_ready <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
    end else begin
      // Handshake pulses last a single cycle unless re-armed below.
      req_ready <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      case (state)
        APB_IDLE: begin
          if (arb_found) begin
            pwrite    <= req_write[arb_idx];
            paddr     <= req_addr[arb_idx*ADDR_WIDTH +: ADDR_WIDTH];
            pwdata    <= req_wdata[arb_idx*DATA_WIDTH +: DATA_WIDTH];
            req_ready <= arb_gnt;
            gnt_q     <= arb_gnt;
            ptr       <= arb_idx;
            psel      <= 1'b1;
            state     <= APB_SETUP;
          end
        end
        APB_SETUP: begin
          penable <= 1'b1;
          wcnt    <= '0;
          state   <= APB_ACCESS;
        end
        APB_ACCESS: begin
          if (pready) begin
            rsp_valid <= gnt_q;
            rsp_rdata <= pwrite ? '0 : prdata;
            psel      <= 1'b0;
            penable   <= 1'b0;
            state     <= APB_IDLE;
          end else if (wcnt == WAIT_LAST) begin
            rsp_valid <= gnt_q;
            rsp_err   <= 1'b1;
            psel      <= 1'b0;
            penable   <= 1'b0;
            state     <= APB_IDLE;
          end else if (wcnt != '1) begin
            wcnt <= wcnt + 1'b1;
          end
        end
        default: begin
          psel    <= 1'b0;
          penable <= 1'b0;
          state   <= APB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_rr_master.sv
// Directed scoreboard bench for apb_rr_master: stimulus queues expected
// grants/responses, a negedge monitor pops and compares them.
module tb_apb_rr_master;

  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int NREQ    = 4;
  localparam int TIMEOUT = 16;

  logic               pclk = 1'b0;
  logic               presetn;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_write;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    rsp_valid;
  logic [DW-1:0]      rsp_rdata;
  logic               rsp_err;
  logic               psel;
  logic               penable;
  logic               pwrite;
  logic [AW-1:0]      paddr;
  logic [DW-1:0]      pwdata;
  logic [DW-1:0]      prdata;
  logic               pready;

  typedef struct {
    logic [NREQ-1:0] oh;
    logic [DW-1:0]   rdata;
    logic            err;
  } rsp_t;

  rsp_t            exp_q[$];
  logic [NREQ-1:0] gnt_q[$];
  rsp_t            mon_e;
  logic [NREQ-1:0] mon_g;
  int              checks = 0;
  int              errors = 0;

  apb_rr_master #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .NREQ       (NREQ),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .pclk      (pclk),
    .presetn   (presetn),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .prdata    (prdata),
    .pready    (pready)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge pclk);
  endtask

  task automatic set_req(input int i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_write[i]         = wr;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic push_rsp(input logic [NREQ-1:0] oh, input logic [DW-1:0] rd, input logic e);
    rsp_t r;
    r.oh    = oh;
    r.rdata = rd;
    r.err   = e;
    exp_q.push_back(r);
  endtask

  task automatic wait_ready(input int i, input string name);
    bit seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      step();
      if (req_ready[i]) seen = 1'b1;
    end
    chk(name, seen, 1'b1);
  endtask

  task automatic wait_idle(input string name);
    bit done = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      step();
      if (exp_q.size() == 0 && gnt_q.size() == 0) done = 1'b1;
    end
    chk(name, done, 1'b1);
    step();
  endtask

  // Scoreboard monitor: every grant and response is matched in order.
  always @(negedge pclk) begin
    if (presetn) begin
      if (rsp_valid != '0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", rsp_valid, '0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("rsp_valid", rsp_valid, mon_e.oh);
          chk("rsp_rdata", rsp_rdata, mon_e.rdata);
          chk("rsp_err", rsp_err, mon_e.err);
        end
      end
      if (req_ready != '0) begin
        if (gnt_q.size() == 0) begin
          chk("unexpected_grant", req_ready, '0);
        end else begin
          mon_g = gnt_q.pop_front();
          chk("grant_order", req_ready, mon_g);
        end
      end
    end
  end

  initial begin
    int cnt[NREQ];
    int acc;
    bit busy;

    presetn   = 1'b0;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    prdata    = '0;
    pready    = 1'b1;

    // Reset with every requester asserting.
    req_valid = 4'hF;
    step();
    step();
    chk("reset_ctrl", {req_ready, rsp_valid, rsp_err, psel, penable, pwrite}, '0);
    chk("reset_paddr", paddr, '0);
    chk("reset_pwdata", pwdata, '0);
    chk("reset_rdata", rsp_rdata, '0);
    prdata = 32'h1111_0000;
    gnt_q.push_back(4'b0001);
    push_rsp(4'b0001, 32'h1111_0000, 1'b0);
    presetn = 1'b1;
    wait_ready(0, "reset_first_grant");
    req_valid = '0;
    wait_idle("t1_idle");

    // Single zero-wait write from requester 0.
    set_req(0, 1'b1, 32'h10, 32'hA5A5_0001);
    gnt_q.push_back(4'b0001);
    push_rsp(4'b0001, '0, 1'b0);
    req_valid[0] = 1'b1;
    step();
    req_valid[0] = 1'b0;
    chk("wr_setup", {psel, penable, pwrite}, 3'b101);
    chk("wr_paddr", paddr, 32'h10);
    chk("wr_pwdata", pwdata, 32'hA5A5_0001);
    step();
    chk("wr_access", {psel, penable}, 2'b11);
    step();
    chk("wr_rsp_time", rsp_valid, 4'b0001);
    chk("wr_bus_drop", {psel, penable}, 2'b00);
    wait_idle("t2_idle");

    // Read from requester 2 with three wait states.
    set_req(2, 1'b0, 32'h20, 32'h0);
    pready = 1'b0;
    prdata = 32'h0BAD_0BAD;
    gnt_q.push_back(4'b0100);
    push_rsp(4'b0100, 32'hDEAD_BEEF, 1'b0);
    req_valid[2] = 1'b1;
    step();
    req_valid[2] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("rd_wait_ctrl", {psel, penable, pwrite, rsp_valid}, {3'b110, 4'b0000});
      chk("rd_wait_paddr", paddr, 32'h20);
    end
    pready = 1'b1;
    prdata = 32'hDEAD_BEEF;
    step();
    chk("rd_rsp_time", rsp_valid, 4'b0100);
    wait_idle("t3_idle");

    // Contention after a fresh reset: order 0,1,2,3,0; requester 1 writes.
    presetn = 1'b0;
    step();
    presetn = 1'b1;
    prdata = 32'h5555_AAAA;
    for (int i = 0; i < NREQ; i++) set_req(i, (i == 1), AW'(32'h0C + 16 * i), DW'(32'h100 + i));
    gnt_q.push_back(4'b0001);
    gnt_q.push_back(4'b0010);
    gnt_q.push_back(4'b0100);
    gnt_q.push_back(4'b1000);
    gnt_q.push_back(4'b0001);
    push_rsp(4'b0001, 32'h5555_AAAA, 1'b0);
    push_rsp(4'b0010, '0, 1'b0);
    push_rsp(4'b0100, 32'h5555_AAAA, 1'b0);
    push_rsp(4'b1000, 32'h5555_AAAA, 1'b0);
    push_rsp(4'b0001, 32'h5555_AAAA, 1'b0);
    cnt = '{2, 1, 1, 1};
    req_valid = 4'hF;
    busy = 1'b1;
    for (int c = 0; c < 100 && busy; c++) begin
      step();
      for (int i = 0; i < NREQ; i++) begin
        if (req_ready[i]) begin
          cnt[i]--;
          if (cnt[i] == 0) req_valid[i] = 1'b0;
        end
      end
      busy = |req_valid;
    end
    chk("contention_done", busy, 1'b0);
    wait_idle("t4_idle");

    // Timeout: slave never raises pready.
    set_req(3, 1'b0, 32'h30, 32'h0);
    pready = 1'b0;
    prdata = 32'hFFFF_FFFF;
    gnt_q.push_back(4'b1000);
    push_rsp(4'b1000, '0, 1'b1);
    req_valid[3] = 1'b1;
    step();
    req_valid[3] = 1'b0;
    acc = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (rsp_valid != '0) break;
      if (psel && penable) acc++;
    end
    chk("timeout_access_cycles", acc, TIMEOUT);
    chk("timeout_bus_drop", {psel, penable}, 2'b00);
    step();
    chk("timeout_idle", {psel, penable}, 2'b00);
    wait_idle("t5_idle");

    // Reset during ACCESS: immediate bus drop, no response, priority resets.
    set_req(1, 1'b0, 32'h40, 32'h0);
    gnt_q.push_back(4'b0010);
    req_valid[1] = 1'b1;
    step();
    req_valid[1] = 1'b0;
    step();
    chk("midrst_in_access", {psel, penable}, 2'b11);
    #2 presetn = 1'b0;
    #1;
    chk("midrst_bus_drop", {psel, penable, rsp_valid}, '0);
    step();
    step();
    presetn = 1'b1;
    pready = 1'b1;
    prdata = 32'h600D_0000;
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, AW'(32'h80 + 4 * i), '0);
    gnt_q.push_back(4'b0001);
    push_rsp(4'b0001, 32'h600D_0000, 1'b0);
    req_valid = 4'hF;
    wait_ready(0, "midrst_priority");
    req_valid = '0;
    wait_idle("t6_idle");

    chk("queues_drained", exp_q.size() + gnt_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
